// File: rtl/instr_sequencer.sv
// instr_sequencer: per-instruction control FSM of the core.
// Sequences single-cycle ops, two-cycle jumps/taken branches and LSU
// request/response handshakes for the one instruction in flight, retires
// it back to fetch, commands PC updates and halts on illegal instructions
// or bus timeouts.
module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        compressed_inst_i,
    input  logic        jump_inst_i,
    input  logic        branch_inst_i,
    input  logic        illegal_inst_i,
    input  logic        rf_we_i,
    input  logic        lsu_r_en_i,
    input  logic        lsu_w_en_i,
    input  logic        branch_taken_i,
    output logic        cycle_counter_o,
    output logic        rf_we_o,
    output logic        lsu_req_o,
    input  logic        lsu_gnt_i,
    input  logic        lsu_rvalid_i,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        flush_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] instret_o
);

    // The counter only has to reach MEM_TIMEOUT-1: the cycle it sits there
    // without rvalid is the last one allowed before the bus-timeout trap.
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SECOND   = 2'd1,
        MEM_WAIT = 2'd2,
        TRAP     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timeout_cnt, timeout_cnt_nxt;
    logic             trap_set;
    logic [1:0]       trap_cause_nxt;

    // The PC register picks the +2/+4 increment itself; the compressed flag
    // is part of the decoder bundle but carries no sequencing meaning here.
    logic unused_compressed;
    assign unused_compressed = compressed_inst_i;

    assign cycle_counter_o = (state == SECOND);

    // Next-state, timeout counter and handshake strobes; all strobes forced
    // low while reset is held so no partial instruction leaks out.
    always_comb begin
        state_nxt       = state;
        timeout_cnt_nxt = timeout_cnt;
        trap_set        = 1'b0;
        trap_cause_nxt  = trap_cause_o;
        instr_ready_o   = 1'b0;
        rf_we_o         = 1'b0;
        lsu_req_o       = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = 1'b0;
        flush_o         = 1'b0;

        case (state)
            RUN: begin
                if (instr_valid_i) begin
                    if (illegal_inst_i) begin
                        state_nxt      = TRAP;
                        trap_set       = 1'b1;
                        trap_cause_nxt = CAUSE_ILLEGAL;
                    end else if (lsu_r_en_i || lsu_w_en_i) begin
                        lsu_req_o = 1'b1;
                        if (lsu_gnt_i) begin
                            state_nxt       = MEM_WAIT;
                            timeout_cnt_nxt = '0;
                        end
                    end else if (jump_inst_i) begin
                        rf_we_o   = rf_we_i;
                        state_nxt = SECOND;
                    end else if (branch_inst_i) begin
                        if (branch_taken_i) begin
                            state_nxt = SECOND;
                        end else begin
                            instr_ready_o = 1'b1;
                            pc_we_o       = 1'b1;
                        end
                    end else begin
                        rf_we_o       = rf_we_i;
                        instr_ready_o = 1'b1;
                        pc_we_o       = 1'b1;
                    end
                end
            end
            SECOND: begin
                pc_we_o       = 1'b1;
                pc_sel_o      = 1'b1;
                flush_o       = 1'b1;
                instr_ready_o = 1'b1;
                state_nxt     = RUN;
            end
            MEM_WAIT: begin
                if (lsu_rvalid_i) begin
                    rf_we_o       = rf_we_i;
                    instr_ready_o = 1'b1;
                    pc_we_o       = 1'b1;
                    state_nxt     = RUN;
                end else if (timeout_cnt == LAST_CNT) begin
                    state_nxt      = TRAP;
                    trap_set       = 1'b1;
                    trap_cause_nxt = CAUSE_BUS;
                end else begin
                    timeout_cnt_nxt = timeout_cnt + 1'b1;
                end
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!rst_n) begin
            instr_ready_o = 1'b0;
            rf_we_o       = 1'b0;
            lsu_req_o     = 1'b0;
            pc_we_o       = 1'b0;
            pc_sel_o      = 1'b0;
            flush_o       = 1'b0;
        end
    end

    // State, timeout counter, sticky trap status and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            timeout_cnt  <= '0;
            trap_o       <= 1'b0;
            trap_cause_o <= 2'd0;
            instret_o    <= 32'd0;
        end else begin
            state       <= state_nxt;
            timeout_cnt <= timeout_cnt_nxt;
            if (trap_set) begin
                trap_o       <= 1'b1;
                trap_cause_o <= trap_cause_nxt;
            end
            if (instr_ready_o) begin
                instret_o <= instret_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: instruction-level expected traces drive the
// DUT cycle by cycle and are compared against its outputs, with literal
// checkpoints on the retire counter and trap status.
module tb_instr_sequencer;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i, compressed_inst_i, jump_inst_i, branch_inst_i;
    logic        illegal_inst_i, rf_we_i, lsu_r_en_i, lsu_w_en_i, branch_taken_i;
    logic        lsu_gnt_i, lsu_rvalid_i;
    logic        instr_ready_o, cycle_counter_o, rf_we_o, lsu_req_o;
    logic        pc_we_o, pc_sel_o, flush_o, trap_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] instret_o;

    typedef struct packed {
        logic rst_n, valid, comp, jump, branch, illegal, rf_we, lr, lw, taken, gnt, rvalid;
    } stim_t;

    typedef struct packed {
        logic ready, rf_we, req, pc_we, pc_sel, flush, cc;
    } strobe_t;

    typedef struct packed {
        stim_t       s;
        strobe_t     e;
        logic        trap_set;
        logic [1:0]  trap_cause;
        logic        pin_en;
        logic [31:0] pin_instret;
        logic        pin_trap;
        logic [1:0]  pin_cause;
    } step_t;

    step_t       trace[$];
    step_t       cur;
    logic        chk_en = 1'b0;
    logic [31:0] m_instret = 32'd0;
    logic        m_trap = 1'b0;
    logic [1:0]  m_cause = 2'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    instr_sequencer #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid_i     (instr_valid_i),
        .instr_ready_o     (instr_ready_o),
        .compressed_inst_i (compressed_inst_i),
        .jump_inst_i       (jump_inst_i),
        .branch_inst_i     (branch_inst_i),
        .illegal_inst_i    (illegal_inst_i),
        .rf_we_i           (rf_we_i),
        .lsu_r_en_i        (lsu_r_en_i),
        .lsu_w_en_i        (lsu_w_en_i),
        .branch_taken_i    (branch_taken_i),
        .cycle_counter_o   (cycle_counter_o),
        .rf_we_o           (rf_we_o),
        .lsu_req_o         (lsu_req_o),
        .lsu_gnt_i         (lsu_gnt_i),
        .lsu_rvalid_i      (lsu_rvalid_i),
        .pc_we_o           (pc_we_o),
        .pc_sel_o          (pc_sel_o),
        .flush_o           (flush_o),
        .trap_o            (trap_o),
        .trap_cause_o      (trap_cause_o),
        .instret_o         (instret_o)
    );

    always #5 clk = ~clk;

    // ---------------- instruction-level trace builders ----------------
    function automatic step_t blank_step();
        step_t st;
        st = '0;
        st.s.rst_n = 1'b1;
        return st;
    endfunction

    function automatic stim_t alu_instr(input logic comp);
        stim_t s;
        s = '0;
        s.rst_n = 1'b1; s.valid = 1'b1; s.rf_we = 1'b1; s.comp = comp;
        return s;
    endfunction

    task automatic add_alu(input logic comp);
        step_t st = blank_step();
        st.s = alu_instr(comp);
        st.e.ready = 1'b1; st.e.rf_we = 1'b1; st.e.pc_we = 1'b1;
        trace.push_back(st);
    endtask

    // Redirect cycle shared by jumps and taken branches.
    task automatic add_redirect(input stim_t s);
        step_t st = blank_step();
        st.s = s;
        st.e.cc = 1'b1; st.e.pc_we = 1'b1; st.e.pc_sel = 1'b1;
        st.e.flush = 1'b1; st.e.ready = 1'b1;
        trace.push_back(st);
    endtask

    task automatic add_jump_first(output stim_t s);
        step_t st = blank_step();
        st.s.valid = 1'b1; st.s.jump = 1'b1; st.s.rf_we = 1'b1;
        st.e.rf_we = 1'b1;
        trace.push_back(st);
        s = st.s;
    endtask

    task automatic add_branch(input logic taken);
        step_t st = blank_step();
        st.s.valid = 1'b1; st.s.branch = 1'b1; st.s.taken = taken;
        if (taken) begin
            trace.push_back(st);
            add_redirect(st.s);
        end else begin
            st.e.ready = 1'b1; st.e.pc_we = 1'b1;
            trace.push_back(st);
        end
    endtask

    // Memory op: gnt_wait cycles of unanswered request, the grant cycle,
    // then rsp_wait-1 silent cycles and the rvalid cycle (rsp_wait=0: never).
    task automatic add_mem(input logic load, input int gnt_wait, input int rsp_wait,
                           input logic early_rvalid);
        step_t st = blank_step();
        st.s.valid = 1'b1; st.s.lr = load; st.s.lw = !load; st.s.rf_we = load;
        for (int i = 0; i < gnt_wait; i++) begin
            step_t w = st;
            w.s.rvalid = early_rvalid;
            w.e.req = 1'b1;
            trace.push_back(w);
        end
        begin
            step_t g = st;
            g.s.gnt = 1'b1; g.e.req = 1'b1;
            trace.push_back(g);
        end
        if (rsp_wait == 0) begin
            for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
                step_t w = st;
                if (i == int'(TB_TIMEOUT) - 1) begin
                    w.trap_set = 1'b1; w.trap_cause = 2'd2;
                end
                trace.push_back(w);
            end
        end else begin
            for (int i = 0; i < rsp_wait - 1; i++) trace.push_back(st);
            begin
                step_t r = st;
                r.s.rvalid = 1'b1;
                r.e.ready = 1'b1; r.e.rf_we = load; r.e.pc_we = 1'b1;
                trace.push_back(r);
            end
        end
    endtask

    task automatic add_illegal();
        step_t st = blank_step();
        st.s.valid = 1'b1; st.s.illegal = 1'b1; st.s.rf_we = 1'b1;
        st.trap_set = 1'b1; st.trap_cause = 2'd1;
        trace.push_back(st);
    endtask

    // Everything asserted on the inputs while halted must be ignored.
    task automatic add_trapped_noise(input int n);
        for (int i = 0; i < n; i++) begin
            step_t st = blank_step();
            st.s = alu_instr(1'b0);
            st.s.gnt = 1'b1; st.s.rvalid = 1'b1; st.s.lr = i[0];
            trace.push_back(st);
        end
    endtask

    task automatic add_reset(input stim_t held);
        step_t st = blank_step();
        st.s = held;
        st.s.rst_n = 1'b0;
        trace.push_back(st);
    endtask

    task automatic add_pin(input logic [31:0] instret, input logic trap, input logic [1:0] cause);
        step_t st = blank_step();
        st.pin_en = 1'b1; st.pin_instret = instret; st.pin_trap = trap; st.pin_cause = cause;
        trace.push_back(st);
    endtask

    // ---------------- driver ----------------
    task automatic apply_stimulus(input step_t st);
        @(posedge clk);
        #1;
        if (chk_en && cur.s.rst_n) begin
            if (cur.e.ready) m_instret = m_instret + 32'd1;
            if (cur.trap_set) begin
                m_trap  = 1'b1;
                m_cause = cur.trap_cause;
            end
        end
        rst_n             = st.s.rst_n;
        instr_valid_i     = st.s.valid;
        compressed_inst_i = st.s.comp;
        jump_inst_i       = st.s.jump;
        branch_inst_i     = st.s.branch;
        illegal_inst_i    = st.s.illegal;
        rf_we_i           = st.s.rf_we;
        lsu_r_en_i        = st.s.lr;
        lsu_w_en_i        = st.s.lw;
        branch_taken_i    = st.s.taken;
        lsu_gnt_i         = st.s.gnt;
        lsu_rvalid_i      = st.s.rvalid;
        if (!st.s.rst_n) begin
            m_instret = 32'd0;
            m_trap    = 1'b0;
            m_cause   = 2'd0;
        end
        cur    = st;
        chk_en = 1'b1;
    endtask

    // ---------------- compare ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_output();
        check_val("instr_ready_o",   {31'd0, instr_ready_o},   {31'd0, cur.e.ready});
        check_val("rf_we_o",         {31'd0, rf_we_o},         {31'd0, cur.e.rf_we});
        check_val("lsu_req_o",       {31'd0, lsu_req_o},       {31'd0, cur.e.req});
        check_val("pc_we_o",         {31'd0, pc_we_o},         {31'd0, cur.e.pc_we});
        check_val("pc_sel_o",        {31'd0, pc_sel_o},        {31'd0, cur.e.pc_sel});
        check_val("flush_o",         {31'd0, flush_o},         {31'd0, cur.e.flush});
        check_val("cycle_counter_o", {31'd0, cycle_counter_o}, {31'd0, cur.e.cc});
        check_val("instret_o",       instret_o,                m_instret);
        check_val("trap_o",          {31'd0, trap_o},          {31'd0, m_trap});
        check_val("trap_cause_o",    {30'd0, trap_cause_o},    {30'd0, m_cause});
        if (cur.pin_en) begin
            check_val("pin instret_o",    instret_o,             cur.pin_instret);
            check_val("pin trap_o",       {31'd0, trap_o},       {31'd0, cur.pin_trap});
            check_val("pin trap_cause_o", {30'd0, trap_cause_o}, {30'd0, cur.pin_cause});
        end
    endtask

    // Outputs are sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) check_output();
    end

    // ---------------- directed sequence ----------------
    initial begin
        stim_t js;
        step_t st;

        rst_n = 1'b0;
        instr_valid_i = 1'b0; compressed_inst_i = 1'b0; jump_inst_i = 1'b0;
        branch_inst_i = 1'b0; illegal_inst_i = 1'b0; rf_we_i = 1'b0;
        lsu_r_en_i = 1'b0; lsu_w_en_i = 1'b0; branch_taken_i = 1'b0;
        lsu_gnt_i = 1'b0; lsu_rvalid_i = 1'b0;

        // Reset with a valid instruction already on the bus: no strobes.
        add_reset(alu_instr(1'b0));
        add_reset(alu_instr(1'b0));
        add_pin(32'd0, 1'b0, 2'd0);

        // ADDI stream, one retire per cycle.
        for (int i = 0; i < 4; i++) add_alu(1'b0);
        add_pin(32'd4, 1'b0, 2'd0);

        // JAL, then branches not taken / taken.
        add_jump_first(js);
        add_redirect(js);
        add_pin(32'd5, 1'b0, 2'd0);
        add_branch(1'b0);
        add_branch(1'b1);
        add_pin(32'd7, 1'b0, 2'd0);

        // LW: grant after 3 cycles, rvalid 2 cycles after grant.
        add_mem(1'b1, 3, 2, 1'b0);
        add_pin(32'd8, 1'b0, 2'd0);
        // SW with stray rvalid while still waiting for grant.
        add_mem(1'b0, 1, 1, 1'b1);
        // LW answered on the very last allowed cycle: no trap.
        add_mem(1'b1, 0, int'(TB_TIMEOUT), 1'b0);
        add_alu(1'b1);
        add_pin(32'd11, 1'b0, 2'd0);

        // Reset in the middle of a jump, then the held jump runs again.
        add_jump_first(js);
        add_reset(js);
        add_jump_first(js);
        add_redirect(js);
        add_pin(32'd1, 1'b0, 2'd0);

        // Reset in the middle of a memory wait.
        st = blank_step();
        st.s.valid = 1'b1; st.s.lr = 1'b1; st.s.rf_we = 1'b1; st.s.gnt = 1'b1;
        st.e.req = 1'b1;
        trace.push_back(st);
        st.s.gnt = 1'b0; st.e = '0;
        trace.push_back(st);
        add_reset(st.s);
        add_alu(1'b0);
        add_pin(32'd1, 1'b0, 2'd0);

        // Store that never gets a response: bus timeout, then halted.
        add_mem(1'b0, 0, 0, 1'b0);
        add_trapped_noise(3);
        add_pin(32'd1, 1'b1, 2'd2);

        // Illegal instruction after a reset.
        add_reset(alu_instr(1'b0));
        add_alu(1'b0);
        add_illegal();
        add_trapped_noise(2);
        add_pin(32'd1, 1'b1, 2'd1);
        add_reset(alu_instr(1'b0));
        add_pin(32'd0, 1'b0, 2'd0);
        add_alu(1'b0);
        add_pin(32'd1, 1'b0, 2'd0);

        $display("[TB] running %0d directed steps", trace.size());
        while (trace.size() > 0) apply_stimulus(trace.pop_front());

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Per-instruction control FSM of the core: it sits between fetch, the decoder, register file, LSU and PC register. It drives the decoder's cycle counter, gates register-file writes, and sequences LSU request/response handshakes. It also retires instructions back to fetch, commands PC updates, and halts the core on illegal instructions or bus timeouts. One instruction is in flight at a time.

## Interface
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles without `lsu_rvalid_i` before a bus-timeout trap (≥2)
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- instr_valid_i  in  1  fetch presents an instruction; held stable until `instr_ready_o`
- instr_ready_o  out  1  instruction retires this cycle
- compressed_inst_i, jump_inst_i, branch_inst_i, illegal_inst_i  in  1 each  decoder class flags
- rf_we_i, lsu_r_en_i, lsu_w_en_i  in  1 each  decoder write/LSU requests
- branch_taken_i  in  1  ALU compare result (bit 0 of ALU out)
- cycle_counter_o  out  1  to decoder `cycle_counter_i`
- rf_we_o  out  1  gated register-file write enable
- lsu_req_o  out  1  LSU request
- lsu_gnt_i  in  1  LSU accepted request
- lsu_rvalid_i  in  1  LSU read data / write acknowledge
- pc_we_o  out  1  PC load strobe
- pc_sel_o  out  1  0: PC += 2/4 (per `compressed_inst_i`), 1: PC = ALU out
- flush_o  out  1  discard fetch prefetch (redirect)
- trap_o  out  1  sticky halt
- trap_cause_o  out  2  0 none, 1 illegal, 2 bus timeout
- instret_o  out  32  retired-instruction counter

## Operation
- States: RUN, SECOND, MEM_WAIT, TRAP. Reset → RUN.
- `cycle_counter_o` = 1 only in SECOND.
- Strobes are combinational from state and inputs. Defaults are all 0 and `pc_sel_o` = 0.
- RUN with `instr_valid_i` = 0: no strobes, stay in RUN.
- RUN with valid and illegal: → TRAP; latch cause 1. No retire, no write.
- RUN, load/store:
  - `lsu_req_o` = 1, held while `lsu_gnt_i` = 0. `rf_we_o` = 0.
  - On gnt → MEM_WAIT; clear timeout counter.
- MEM_WAIT:
  - `lsu_req_o` = 0.
  - On `lsu_rvalid_i`: `rf_we_o` = `rf_we_i`, `instr_ready_o` = 1, `pc_we_o` = 1 (sequential), → RUN.
  - Otherwise the counter increments. After MEM_TIMEOUT non-rvalid cycles → TRAP, cause 2.
  - rvalid on the final cycle wins over timeout.
- RUN, jump: `rf_we_o` = `rf_we_i` (link write, decoder imm = PC inc) → SECOND.
- RUN, branch:
  - Taken: no write → SECOND.
  - Not taken: `instr_ready_o` = 1, `pc_we_o` = 1, `pc_sel_o` = 0, stay in RUN.
- SECOND: `pc_we_o` = 1, `pc_sel_o` = 1, `flush_o` = 1, `instr_ready_o` = 1, `rf_we_o` = 0 → RUN.
- RUN, any other valid instruction: `rf_we_o` = `rf_we_i`, `instr_ready_o` = 1, `pc_we_o` = 1, `pc_sel_o` = 0.
- `instret_o` increments on every `instr_ready_o`, wrapping 2^32−1 → 0.
- TRAP:
  - All strobes 0.
  - `trap_o` = 1 and `trap_cause_o` held until reset.
  - `instr_valid_i` and LSU inputs are ignored.
- `instr_valid_i` is ignored outside RUN; fetch must hold the instruction.

## Timing
- Reset values:
  - State RUN, `trap_o` = 0, `trap_cause_o` = 0, `instret_o` = 0, timeout counter 0.
  - All strobes 0 while `rst_n` low.
- Single-cycle ops retire in the cycle valid is seen; throughput is 1 per cycle.
- Jump or taken branch: 2 cycles; `flush_o` in cycle 2.
- Load/store: minimum 2 cycles (gnt in cycle 1, rvalid in cycle 2). `lsu_rvalid_i` in RUN is ignored.
- `trap_o` and `trap_cause_o` are registered: they assert on the edge after the trigger cycle.
- `instret_o` is registered: it updates on the edge after `instr_ready_o`.
- Reset mid-MEM_WAIT or mid-SECOND: immediate return to RUN. No retire, no instret change.

## Test plan
- ADDI stream, valid held 4 cycles → `instr_ready_o` = 1 each cycle, `rf_we_o` = 1, `pc_sel_o` = 0, `instret_o` = 4.
- JAL → cycle 0 `rf_we_o` = 1 and `cycle_counter_o` = 0. Cycle 1 `cycle_counter_o` = 1, `pc_we_o` = `pc_sel_o` = `flush_o` = 1. `instret_o` +1.
- BEQ with taken = 0 → retire in 1 cycle, `pc_sel_o` = 0. With taken = 1 → 2 cycles, `pc_sel_o` = 1 in cycle 2. `rf_we_o` never 1.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt → `lsu_req_o` high 4 cycles. `rf_we_o` and `instr_ready_o` only in the rvalid cycle. Total 6 cycles.
- Store, MEM_TIMEOUT = 4, rvalid never → `trap_o` = 1, cause 2, after 4 MEM_WAIT cycles. Later valid instructions produce no strobes.
- Illegal instruction → `trap_o` = 1, cause 1, next edge. `instret_o` unchanged. `rst_n` pulse clears to RUN with `instret_o` = 0.
